// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: FSM encoding, queue entry layout
// and the default reset fetch address.
package fetch_pkg;

   localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      FULL    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instr} entries between fetch and decode.
// Ports: clock, reset, push/pop/flush, push_pc/push_instr in,
// head_pc/head_instr (zero-latency head), count, full, empty.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  logic [31:0]                  push_pc,
   input  logic [31:0]                  push_instr,
   output logic [31:0]                  head_pc,
   output logic [31:0]                  head_instr,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   fq_entry_t       mem_q [DEPTH];
   logic [PW-1:0]   rd_q;
   logic [PW-1:0]   wr_q;
   logic [CW-1:0]   cnt_q;

   // Storage needs no reset; validity is tracked by cnt_q.
   always_ff @(posedge clock) begin
      if (push)
         mem_q[wr_q] <= '{pc: push_pc, instr: push_instr};
   end

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push)
            wr_q <= wr_q + 1'b1;
         if (pop)
            rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
   end

   assign head_pc    = mem_q[rd_q].pc;
   assign head_instr = mem_q[rd_q].instr;
   assign count      = cnt_q;
   assign full       = (cnt_q == CW'(DEPTH));
   assign empty      = (cnt_q == '0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, small instruction
// queue to decode, redirect flush with stale-response discard.
// Ports: clock, reset; imem_req/imem_addr out, imem_ack/imem_rdata in;
// redirect_valid/redirect_pc in; out_valid/out_instr/out_pc/out_pc4
// out, out_ready in; align_err out.
// Macro FETCH_ALIGN_CHECK_EN: flag misaligned redirects (sticky
// align_err) and force the loaded fetch_pc to word alignment.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = FETCH_RESET_PC,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc4,
   output logic        align_err
);

   localparam int CW = $clog2(QUEUE_DEPTH + 1);

   fetch_state_e  state_q;
   logic          req_q;
   logic [31:0]   addr_q;
   logic [31:0]   pc_q;

   logic          acc;
   logic          flush;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          full_nxt;
   logic [31:0]   pc_load;
   logic [31:0]   pc_nxt;

   assign acc   = req_q & imem_ack;
   assign flush = redirect_valid;
   // Responses are only kept in FETCH; in DISCARD they are stale.
   assign push  = acc & (state_q == FETCH) & ~flush;
   assign pop   = out_valid & out_ready & ~flush;

`ifdef FETCH_ALIGN_CHECK_EN
   logic aerr_q;

   assign pc_load = {redirect_pc[31:2], 2'b00};

   always_ff @(posedge clock) begin
      if (reset)
         aerr_q <= 1'b0;
      else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
         aerr_q <= 1'b1;
   end

   assign align_err = aerr_q;
`else
   assign pc_load   = redirect_pc;
   assign align_err = 1'b0;
`endif

   // Fullness after this edge; a push never lands on a full queue
   // because no request issues while full.
   always_comb begin
      full_nxt = 1'b0;
      if (!flush) begin
         if (pop)
            full_nxt = 1'b0;
         else if (push)
            full_nxt = (count == CW'(QUEUE_DEPTH - 1));
         else
            full_nxt = full;
      end
   end

   always_comb begin
      pc_nxt = pc_q;
      if (flush)
         pc_nxt = pc_load;
      else if (push)
         pc_nxt = pc_q + 32'd4;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= FETCH;
         req_q   <= 1'b0;
         addr_q  <= RESET_PC;
         pc_q    <= RESET_PC;
      end else begin
         pc_q <= pc_nxt;
         if (req_q && !imem_ack) begin
            // Request must stay stable until acked.
            if (flush)
               state_q <= DISCARD;
         end else begin
            req_q   <= ~full_nxt;
            addr_q  <= pc_nxt;
            state_q <= full_nxt ? FULL : FETCH;
         end
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = addr_q;

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clock      (clock),
      .reset      (reset),
      .push       (push),
      .pop        (pop),
      .flush      (flush),
      .push_pc    (pc_q),
      .push_instr (imem_rdata),
      .head_pc    (out_pc),
      .head_instr (out_instr),
      .count      (count),
      .full       (full),
      .empty      (empty)
   );

   assign out_valid = ~empty;
   assign out_pc4   = out_pc + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage with an in-order scoreboard of
// fetched {pc, instr} entries checked against the decode side.
module tb_fetch_stage;

   logic        clock;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc4;
   logic        align_err;

`ifdef FETCH_ALIGN_CHECK_EN
   localparam bit ALN = 1'b1;
`else
   localparam bit ALN = 1'b0;
`endif

   typedef struct {
      logic        ack;
      logic        rdy;
      logic        redir;
      logic [31:0] rpc;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic        e_push;
      logic        e_aerr;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb[$];
   int   npass;
   int   ntot;
   int   row;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   fetch_stage #(
      .RESET_PC    (32'h0000_0000),
      .QUEUE_DEPTH (2)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_pc4        (out_pc4),
      .align_err      (align_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      ntot++;
      if (act === exp)
         npass++;
      else
         $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
   endtask

   task automatic add(input logic ack, input logic rdy, input logic redir,
                      input logic [31:0] rpc, input logic req,
                      input logic [31:0] addr, input logic vld,
                      input logic psh, input logic ae);
      vec_t v;
      v.ack = ack; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
      v.e_req = req; v.e_addr = addr; v.e_valid = vld;
      v.e_push = psh; v.e_aerr = ae;
      vecs.push_back(v);
   endtask

   initial begin
      logic [31:0] a;
      sb_t         e;
      npass = 0;
      ntot  = 0;
      row   = -1;
      a     = ALN ? 32'h100 : 32'h102;

      //   ack rdy red rpc            req addr          vld psh ae
      add(1, 1, 0, 32'h0,          0, 32'h0,          0, 0, 0);
      add(1, 1, 0, 32'h0,          1, 32'h0,          0, 1, 0);
      add(1, 1, 0, 32'h0,          1, 32'h4,          1, 1, 0);
      add(1, 1, 0, 32'h0,          1, 32'h8,          1, 1, 0);
      add(1, 0, 0, 32'h0,          1, 32'hC,          1, 1, 0);
      add(1, 0, 0, 32'h0,          0, 32'h0,          1, 0, 0);
      add(1, 0, 0, 32'h0,          0, 32'h0,          1, 0, 0);
      add(1, 1, 0, 32'h0,          0, 32'h0,          1, 0, 0);
      add(0, 1, 0, 32'h0,          1, 32'h10,         1, 0, 0);
      add(0, 0, 1, 32'h100,        1, 32'h10,         0, 0, 0);
      add(0, 0, 0, 32'h0,          1, 32'h10,         0, 0, 0);
      add(1, 0, 0, 32'h0,          1, 32'h10,         0, 0, 0);
      add(0, 1, 0, 32'h0,          1, 32'h100,        0, 0, 0);
      add(1, 0, 0, 32'h0,          1, 32'h100,        0, 1, 0);
      add(1, 0, 0, 32'h0,          1, 32'h104,        1, 1, 0);
      add(0, 1, 0, 32'h0,          0, 32'h0,          1, 0, 0);
      add(0, 1, 0, 32'h0,          1, 32'h108,        1, 0, 0);
      add(1, 0, 0, 32'h0,          1, 32'h108,        0, 1, 0);
      add(1, 1, 1, 32'h200,        1, 32'h10C,        1, 0, 0);
      add(0, 1, 0, 32'h0,          1, 32'h200,        0, 0, 0);
      add(1, 1, 1, 32'h102,        1, 32'h200,        0, 0, 0);
      add(0, 1, 0, 32'h0,          1, a,              0, 0, ALN);
      add(1, 1, 0, 32'h0,          1, a,              0, 1, ALN);
      add(0, 1, 0, 32'h0,          1, a + 32'd4,      1, 0, ALN);
      add(0, 1, 1, 32'h300,        1, a + 32'd4,      0, 0, ALN);
      add(0, 0, 1, 32'hFFFF_FFFC,  1, a + 32'd4,      0, 0, ALN);
      add(1, 0, 0, 32'h0,          1, a + 32'd4,      0, 0, ALN);
      add(1, 0, 0, 32'h0,          1, 32'hFFFF_FFFC,  0, 1, ALN);
      add(0, 1, 0, 32'h0,          1, 32'h0,          1, 0, ALN);
      add(0, 1, 0, 32'h0,          1, 32'h0,          0, 0, ALN);

      reset          = 1'b1;
      imem_ack       = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      repeat (2) @(negedge clock);
      chk("rst_req", 32'(imem_req), 32'(0));
      chk("rst_valid", 32'(out_valid), 32'(0));
      chk("rst_aerr", 32'(align_err), 32'(0));
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         row            = i;
         imem_ack       = vecs[i].ack;
         out_ready      = vecs[i].rdy;
         redirect_valid = vecs[i].redir;
         redirect_pc    = vecs[i].rpc;
         #1;
         chk("req", 32'(imem_req), 32'(vecs[i].e_req));
         if (vecs[i].e_req)
            chk("addr", imem_addr, vecs[i].e_addr);
         chk("valid", 32'(out_valid), 32'(vecs[i].e_valid));
         chk("aerr", 32'(align_err), 32'(vecs[i].e_aerr));
         if (vecs[i].e_valid) begin
            if (sb.size() == 0) begin
               ntot++;
               $display("FAIL sb_empty row %0d: got 0 want >0 entries", i);
            end else begin
               chk("out_pc", out_pc, sb[0].pc);
               chk("out_instr", out_instr, sb[0].instr);
               chk("out_pc4", out_pc4, sb[0].pc + 32'd4);
               if (vecs[i].rdy && !vecs[i].redir)
                  void'(sb.pop_front());
            end
         end
         if (vecs[i].e_push) begin
            e.pc    = vecs[i].e_addr;
            e.instr = mem_word(vecs[i].e_addr);
            sb.push_back(e);
         end
         if (vecs[i].redir)
            sb.delete();
         @(negedge clock);
      end

      // Reset during an outstanding request, with ack and a misaligned
      // redirect also asserted: reset must win.
      row            = 100;
      reset          = 1'b1;
      imem_ack       = 1'b1;
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h102;
      @(negedge clock);
      #1;
      chk("mid_rst_req", 32'(imem_req), 32'(0));
      chk("mid_rst_valid", 32'(out_valid), 32'(0));
      chk("mid_rst_aerr", 32'(align_err), 32'(0));
      row            = 101;
      reset          = 1'b0;
      imem_ack       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      @(negedge clock);
      #1;
      chk("post_rst_req", 32'(imem_req), 32'(1));
      chk("post_rst_addr", imem_addr, 32'h0);
      chk("post_rst_valid", 32'(out_valid), 32'(0));

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000: byte address of the first fetch after reset.
REQ-002 Parameter QUEUE_DEPTH, 2: instruction queue entries; legal values 2 or 4.
REQ-003 Port clock, input, 1: single clock; all state updates on posedge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port imem_req, output, 1: fetch request to instruction memory.
REQ-006 Port imem_addr, output, 32: byte address of the request.
REQ-007 Port imem_ack, input, 1: memory accepts the request; data valid in the same cycle.
REQ-008 Port imem_rdata, input, 32: instruction word, valid when imem_req && imem_ack.
REQ-009 Port redirect_valid, input, 1: branch or jump taken; flush and refetch.
REQ-010 Port redirect_pc, input, 32: new fetch address, sampled when redirect_valid=1.
REQ-011 Port out_valid, output, 1: an instruction is presented to decode.
REQ-012 Port out_ready, input, 1: decode consumes the head entry this cycle.
REQ-013 Port out_instr, output, 32: head-entry instruction.
REQ-014 Port out_pc, output, 32: head-entry instruction address.
REQ-015 Port out_pc4, output, 32: out_pc + 4, modulo 2^32.
REQ-016 Port align_err, output, 1: sticky misaligned-redirect flag (see Configuration).

Function
REQ-017 States: FETCH (request may issue), FULL (queue full, no request), DISCARD (outstanding request is stale).
REQ-018 imem_req=1 in FETCH whenever the queue is not full; at most one request is outstanding.
REQ-019 Once asserted, imem_req and imem_addr hold stable until the imem_ack cycle.
REQ-020 Accepted response (req&&ack) in FETCH with no redirect: push {fetch_pc, imem_rdata}; fetch_pc += 4, wrapping at 2^32.
REQ-021 Push when count = QUEUE_DEPTH-1 without a pop: next state FULL, imem_req=0 next cycle.
REQ-022 FULL -> FETCH the cycle after a pop; push and pop in the same cycle leave count unchanged.
REQ-023 out_valid = (count != 0); pop on out_valid && out_ready; out_* reflect the head entry with zero latency.
REQ-024 redirect_valid flushes the queue, so out_valid=0 the next cycle, and loads fetch_pc = redirect_pc.
REQ-025 If redirect_valid arrives with a request outstanding and no ack that cycle, next state is DISCARD; the old imem_addr is held until ack, and that data is dropped.
REQ-026 In DISCARD, the ack cycle returns the FSM to FETCH; the first new request issues the following cycle at the redirected fetch_pc.
REQ-027 Redirect in the same cycle as ack: the response is dropped, there is no push, and the state goes to FETCH with fetch_pc = redirect_pc.
REQ-028 Redirect in the same cycle as a pop: the flush takes priority and the pop is ignored.
REQ-029 A second redirect while in DISCARD overwrites fetch_pc; the FSM remains in DISCARD.

Reset
REQ-030 Reset applies on posedge clock while reset=1 and overrides redirect and ack.
REQ-031 Reset values: state=FETCH, fetch_pc=RESET_PC, count=0, out_valid=0, imem_req=0, align_err=0.
REQ-032 Reset in mid-request abandons the transaction; the first post-reset request issues the cycle after reset deasserts.

Configuration
REQ-033 Macro FETCH_ALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 sets align_err (sticky until reset), and fetch_pc loads {redirect_pc[31:2],2'b00}.
REQ-034 Macro FETCH_ALIGN_CHECK_EN undefined: align_err is tied 0, and redirect_pc loads unmodified.

Structure
REQ-035 Package fetch_pkg holds the state encoding (FETCH, FULL, DISCARD) and the default RESET_PC constant.
REQ-036 Sub-module fetch_queue: a synchronous FIFO of {pc, instr} entries with push, pop, flush, count, full, and empty.

Verification
REQ-037 Reset, then ack every cycle with out_ready=1 -> imem_addr 0,4,8,...; out_pc/out_instr match in order; out_pc4 = out_pc+4.
REQ-038 out_ready=0 with ack always 1, QUEUE_DEPTH=2 -> exactly 2 pushes, imem_req=0 from the third cycle, and no further address advance.
REQ-039 Request at 0x10 outstanding, redirect to 0x100, ack 2 cycles later -> data for 0x10 is dropped and the next imem_addr is 0x100.
REQ-040 Redirect to 0x200 in the same cycle as ack at 0x20 -> no push, out_valid=0 next cycle, and the next imem_addr is 0x200.
REQ-041 fetch_pc=32'hFFFF_FFFC fetched -> out_pc4=0 and the next imem_addr=0.
REQ-042 With FETCH_ALIGN_CHECK_EN, redirect to 0x102 -> align_err=1 (stays 1) and imem_addr=0x100; without the macro, align_err stays 0.
